// File: rtl/prefetch_fetch_unit.sv
// Instruction fetch stage with a DEPTH-entry prefetch queue.
// Holds the fetch PC, buffers imem words with their PCs, and supports redirect and sticky halt.
module prefetch_fetch_unit #(
    parameter int DEPTH  = 4,
    parameter int WORD_W = 32,
    parameter int ADDR_W = 32,
    parameter logic [ADDR_W-1:0] PC_INIT = '0
) (
    input  logic                         CLK,
    input  logic                         RST,
    output logic                         imemREN,
    output logic [ADDR_W-1:0]            imemaddr,
    input  logic                         ihit,
    input  logic [WORD_W-1:0]            imemload,
    input  logic                         redirect,
    input  logic [ADDR_W-1:0]            redirect_pc,
    input  logic                         halt,
    input  logic                         deq,
    output logic                         instr_valid,
    output logic [WORD_W-1:0]            instr,
    output logic [ADDR_W-1:0]            instr_pc,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic {S_RUN, S_HALT} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_pc;
    logic [PW-1:0]       r_head;
    logic [PW-1:0]       r_tail;
    logic [CW-1:0]       r_count;
    logic [WORD_W-1:0]   r_mem_instr [DEPTH];
    logic [ADDR_W-1:0]   r_mem_pc    [DEPTH];
    logic                w_push;
    logic                w_pop;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Redirect wins over halt in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        if (r_state == S_RUN && halt && !redirect) begin
            w_state_nxt = S_HALT;
        end
    end

    always_comb begin
        imemREN = (r_state == S_RUN) && (r_count < CW'(DEPTH))
                  && !redirect && !RST;
    end

    assign imemaddr    = r_pc;
    assign w_push      = imemREN && ihit;
    assign instr_valid = (r_count != '0);
    assign w_pop       = deq && instr_valid && !redirect;
    assign count       = r_count;
    assign instr       = instr_valid ? r_mem_instr[r_head] : '0;
    assign instr_pc    = instr_valid ? r_mem_pc[r_head] : '0;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_pc    <= PC_INIT;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (redirect) begin
            r_pc    <= {redirect_pc[ADDR_W-1:2], 2'b00};
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PW'(1);
                r_pc   <= r_pc + ADDR_W'(4);
            end
            if (w_pop) begin
                r_head <= r_head + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem_instr[r_tail] <= imemload;
            r_mem_pc[r_tail]    <= r_pc;
        end
    end

endmodule

// File: tb/tb_prefetch_fetch_unit.sv
// Directed table-driven bench for prefetch_fetch_unit.
// Vectors are applied on the falling edge and compared one step later.
module tb_prefetch_fetch_unit;

    logic        CLK;
    logic        RST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        deq;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [2:0]  count;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        ihit;
        logic        deq;
        logic        rdr;
        logic [31:0] rpc;
        logic        halt;
        logic        e_ren;
        logic [31:0] e_addr;
        logic [2:0]  e_cnt;
        logic [31:0] e_ipc;
    } vec_t;

    vec_t vecs[$];

    prefetch_fetch_unit #(
        .DEPTH(4),
        .WORD_W(32),
        .ADDR_W(32),
        .PC_INIT(32'h40)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .imemREN(imemREN),
        .imemaddr(imemaddr),
        .ihit(ihit),
        .imemload(imemload),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .halt(halt),
        .deq(deq),
        .instr_valid(instr_valid),
        .instr(instr),
        .instr_pc(instr_pc),
        .count(count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input logic ih, input logic dq, input logic rd,
                       input logic [31:0] rp, input logic hl,
                       input logic ren, input logic [31:0] addr,
                       input logic [2:0] cnt, input logic [31:0] ipc);
        vec_t v;
        v.ihit = ih; v.deq = dq; v.rdr = rd; v.rpc = rp; v.halt = hl;
        v.e_ren = ren; v.e_addr = addr; v.e_cnt = cnt; v.e_ipc = ipc;
        vecs.push_back(v);
    endtask

    initial begin
        logic [31:0] e_instr;
        // fill from reset, then full
        add(1, 0, 0, 0, 0, 1, 32'h40, 0, 32'h0);
        add(1, 0, 0, 0, 0, 1, 32'h44, 1, 32'h40);
        add(1, 0, 0, 0, 0, 1, 32'h48, 2, 32'h40);
        add(1, 0, 0, 0, 0, 1, 32'h4C, 3, 32'h40);
        add(1, 0, 0, 0, 0, 0, 32'h50, 4, 32'h40);
        // single deq on full queue, refill next cycle
        add(1, 1, 0, 0, 0, 0, 32'h50, 4, 32'h40);
        add(1, 0, 0, 0, 0, 1, 32'h50, 3, 32'h44);
        add(0, 0, 0, 0, 0, 0, 32'h54, 4, 32'h44);
        // steady streaming through pointer wrap
        add(1, 1, 0, 0, 0, 0, 32'h54, 4, 32'h44);
        for (int j = 0; j < 9; j++) begin
            add(1, 1, 0, 0, 0, 1, 32'h54 + 4 * j, 3, 32'h48 + 4 * j);
        end
        // redirect with concurrent ihit
        add(1, 0, 1, 32'h203, 0, 0, 32'h78, 3, 32'h6C);
        add(0, 0, 0, 0, 0, 1, 32'h200, 0, 32'h0);
        add(1, 0, 0, 0, 0, 1, 32'h200, 0, 32'h0);
        add(1, 0, 0, 0, 0, 1, 32'h204, 1, 32'h200);
        // halt together with a push, then drain
        add(1, 0, 0, 0, 1, 1, 32'h208, 2, 32'h200);
        add(1, 1, 0, 0, 1, 0, 32'h20C, 3, 32'h200);
        add(1, 1, 0, 0, 1, 0, 32'h20C, 2, 32'h204);
        add(1, 1, 0, 0, 0, 0, 32'h20C, 1, 32'h208);
        add(1, 1, 0, 0, 0, 0, 32'h20C, 0, 32'h0);
        add(1, 0, 0, 0, 0, 0, 32'h20C, 0, 32'h0);
        // redirect while halted
        add(1, 0, 1, 32'h300, 0, 0, 32'h20C, 0, 32'h0);
        add(1, 0, 0, 0, 0, 0, 32'h300, 0, 32'h0);

        RST = 1'b1; ihit = 0; imemload = 0; redirect = 0;
        redirect_pc = 0; halt = 0; deq = 0;
        #1;
        chk("rst.ren", {31'b0, imemREN}, 32'h0);
        chk("rst.addr", imemaddr, 32'h40);
        chk("rst.cnt", {29'b0, count}, 32'h0);
        chk("rst.valid", {31'b0, instr_valid}, 32'h0);
        chk("rst.instr", instr, 32'h0);
        chk("rst.ipc", instr_pc, 32'h0);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;

        foreach (vecs[i]) begin
            ihit        = vecs[i].ihit;
            deq         = vecs[i].deq;
            redirect    = vecs[i].rdr;
            redirect_pc = vecs[i].rpc;
            halt        = vecs[i].halt;
            imemload    = vecs[i].e_addr + 32'h1000;
            #1;
            e_instr = (vecs[i].e_cnt != 0) ? vecs[i].e_ipc + 32'h1000 : 32'h0;
            chk($sformatf("v%0d.ren", i), {31'b0, imemREN},
                {31'b0, vecs[i].e_ren});
            chk($sformatf("v%0d.addr", i), imemaddr, vecs[i].e_addr);
            chk($sformatf("v%0d.cnt", i), {29'b0, count},
                {29'b0, vecs[i].e_cnt});
            chk($sformatf("v%0d.valid", i), {31'b0, instr_valid},
                {31'b0, (vecs[i].e_cnt != 0)});
            chk($sformatf("v%0d.instr", i), instr, e_instr);
            chk($sformatf("v%0d.ipc", i), instr_pc, vecs[i].e_ipc);
            @(negedge CLK);
        end

        // reset leaves HALT, then async reset mid-stream
        ihit = 0; deq = 0; redirect = 0; halt = 0;
        RST = 1'b1;
        #1;
        chk("rst2.ren", {31'b0, imemREN}, 32'h0);
        chk("rst2.addr", imemaddr, 32'h40);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        chk("run.ren", {31'b0, imemREN}, 32'h1);
        ihit = 1'b1;
        for (int k = 0; k < 3; k++) begin
            imemload = 32'h1040 + 4 * k;
            @(negedge CLK);
        end
        #1;
        chk("run.cnt", {29'b0, count}, 32'h3);
        chk("run.ipc", instr_pc, 32'h40);
        chk("run.addr", imemaddr, 32'h4C);
        @(posedge CLK);
        #3;
        RST = 1'b1;
        #1;
        chk("arst.cnt", {29'b0, count}, 32'h0);
        chk("arst.valid", {31'b0, instr_valid}, 32'h0);
        chk("arst.ren", {31'b0, imemREN}, 32'h0);
        chk("arst.instr", instr, 32'h0);
        @(negedge CLK);
        RST = 1'b0;
        ihit = 1'b0;
        #1;
        chk("post.addr", imemaddr, 32'h40);
        chk("post.ren", {31'b0, imemREN}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
